prm_chk_seq: RTL

- Sequencer for the primitive-check accumulator (4096-bit OR-accumulated edge mask, 32-bit word readout via sel1/sel2, registered xyz input).
- On start: clears the accumulator, sweeps every (x,y,z) point of a configured grid into the checker's xyz input, waits for the mask pipeline to drain, then streams all 128 result words out on a valid/ready port.
- Sits between the host/command logic and the checker instance, which it owns exclusively.

---
 rtl/prm_chk_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prm_chk_seq.sv
// Run sequencer for the primitive-check accumulator: clear, sweep an (x,y,z) grid into the
// checker, let the mask pipeline drain, then stream the 128 result words out over valid/ready.
module prm_chk_seq #(
   parameter int XW        = 4,
   parameter int YW        = 5,
   parameter int ZW        = 5,
   parameter int DRAIN_CYC = 4
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic                start,
   input  logic                abort,
   input  logic [XW-1:0]       x_max,
   input  logic [YW-1:0]       y_max,
   input  logic [ZW-1:0]       z_max,
   input  logic [7:0]          settle,
   output logic                chk_rst_n,
   output logic [XW+YW+ZW-1:0] xyz_out,
   output logic [2:0]          sel1,
   output logic [7:0]          sel2,
   input  logic [31:0]         rd_word,
   output logic [31:0]         m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_RD_SEL, S_RD_OUT, S_DONE
   } state_t;

   state_t                r_state;
   logic [XW-1:0]         r_x_max, r_x;
   logic [YW-1:0]         r_y_max, r_y;
   logic [ZW-1:0]         r_z_max, r_z;
   logic [7:0]            r_settle, r_dwell, r_drain;
   logic [6:0]            r_w;
   logic                  r_chk_rst_n, r_m_valid, r_m_last, r_busy, r_done;
   logic [XW+YW+ZW-1:0]   r_xyz;
   logic [2:0]            r_sel1;
   logic [7:0]            r_sel2;
   logic [31:0]           r_m_data;

   logic                  w_z_wrap, w_y_wrap, w_last_pt, w_dwell_end, w_drain_end;
   logic [XW-1:0]         w_x_nxt;
   logic [YW-1:0]         w_y_nxt;
   logic [ZW-1:0]         w_z_nxt;
   logic [6:0]            w_w_nxt;

   assign w_z_wrap    = (r_z == r_z_max);
   assign w_y_wrap    = (r_y == r_y_max);
   assign w_last_pt   = w_z_wrap && w_y_wrap && (r_x == r_x_max);
   assign w_dwell_end = (r_dwell == r_settle);
   assign w_drain_end = (r_drain == 8'(DRAIN_CYC - 1));
   assign w_w_nxt     = r_w + 7'd1;

   // z runs fastest; y and x only step when the faster axis wraps
   assign w_z_nxt = w_z_wrap ? '0 : r_z + ZW'(1);
   assign w_y_nxt = !w_z_wrap ? r_y : (w_y_wrap ? '0 : r_y + YW'(1));
   assign w_x_nxt = (w_z_wrap && w_y_wrap) ? r_x + XW'(1) : r_x;

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_state     <= S_IDLE;
         r_x_max     <= '0;
         r_y_max     <= '0;
         r_z_max     <= '0;
         r_settle    <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_dwell     <= '0;
         r_drain     <= '0;
         r_w         <= '0;
         r_chk_rst_n <= 1'b1;
         r_xyz       <= '0;
         r_sel1      <= '0;
         r_sel2      <= '0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (abort && r_state != S_IDLE) begin
         r_state     <= S_IDLE;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_chk_rst_n <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x_max     <= x_max;
                  r_y_max     <= y_max;
                  r_z_max     <= z_max;
                  r_settle    <= settle;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_z         <= '0;
                  r_dwell     <= '0;
                  r_drain     <= '0;
                  r_w         <= '0;
                  r_xyz       <= '0;
                  r_chk_rst_n <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_chk_rst_n <= 1'b1;
               r_xyz       <= '0;
               r_state     <= S_SCAN;
            end
            S_SCAN: begin
               if (!w_dwell_end) begin
                  r_dwell <= r_dwell + 8'd1;
               end else if (w_last_pt) begin
                  r_drain <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_dwell <= '0;
                  r_x     <= w_x_nxt;
                  r_y     <= w_y_nxt;
                  r_z     <= w_z_nxt;
                  r_xyz   <= {w_x_nxt, w_y_nxt, w_z_nxt};
               end
            end
            S_DRAIN: begin
               if (w_drain_end) begin
                  r_w     <= '0;
                  r_sel1  <= '0;
                  r_sel2  <= '0;
                  r_state <= S_RD_SEL;
               end else begin
                  r_drain <= r_drain + 8'd1;
               end
            end
            S_RD_SEL: begin
               // sel has been stable for this whole cycle, so rd_word reflects word r_w
               r_m_data  <= rd_word;
               r_m_valid <= 1'b1;
               r_m_last  <= (r_w == 7'd127);
               r_state   <= S_RD_OUT;
            end
            S_RD_OUT: begin
               if (r_m_valid && m_ready) begin
                  r_m_valid <= 1'b0;
                  r_m_last  <= 1'b0;
                  if (r_w == 7'd127) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     r_w     <= w_w_nxt;
                     r_sel1  <= w_w_nxt[6:4];
                     r_sel2  <= {4'b0000, w_w_nxt[3:0]};
                     r_state <= S_RD_SEL;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign chk_rst_n = r_chk_rst_n;
   assign xyz_out   = r_xyz;
   assign sel1      = r_sel1;
   assign sel2      = r_sel2;
   assign m_data    = r_m_data;
   assign m_valid   = r_m_valid;
   assign m_last    = r_m_last;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
